// File: rtl/gray_down_counter_4b.sv
// Cascadable 4-bit Gray-code down counter with binary preset, optional auto-reload,
// combinational borrow (tc) and a decoded binary view of the count.

module ms_dff (
    input  logic clk,
    input  logic ce,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk) begin
        if (ce) q <= d;
    end
endmodule

module gray_down_counter_4b #(
    parameter bit         AUTO_RELOAD = 1'b0,
    parameter logic [3:0] RESET_VAL   = 4'b0000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       cten,
    input  logic       ld,
    input  logic [3:0] din,
    output logic [3:0] out,
    output logic [3:0] bin,
    output logic       tc
);
    logic [3:0] out_d;
    logic [3:0] rl_q, rl_d;
    logic [3:0] ld_g, dec_g, wrap_g, tgl;
    logic       par, zero;
    logic       s_rst, s_ld, s_dec, s_wrap, s_hold;

    assign ld_g = {din[3], din[3] ^ din[2], din[2] ^ din[1], din[1] ^ din[0]};
    assign zero = ~out[3] & ~out[2] & ~out[1] & ~out[0];

    // Reflected-Gray decrement: odd parity flips bit 0, even parity flips the bit
    // left of the lowest set bit. Zero has no such bit and is handled as underflow.
    assign par    = out[3] ^ out[2] ^ out[1] ^ out[0];
    assign tgl[0] = par;
    assign tgl[1] = ~par & out[0];
    assign tgl[2] = ~par & ~out[0] & out[1];
    assign tgl[3] = ~par & ~out[0] & ~out[1] & out[2];
    assign dec_g  = out ^ tgl;

    assign wrap_g = AUTO_RELOAD ? {rl_q[3], rl_q[3] ^ rl_q[2], rl_q[2] ^ rl_q[1], rl_q[1] ^ rl_q[0]}
                                : 4'b1000;

    // One-hot select terms encode the priority clr > ld > cten > hold.
    assign s_rst  = ~clr;
    assign s_ld   = clr & ld;
    assign s_dec  = clr & ~ld & cten & ~zero;
    assign s_wrap = clr & ~ld & cten & zero;
    assign s_hold = clr & ~ld & ~cten;

    assign out_d = ({4{s_rst}}  & RESET_VAL)
                 | ({4{s_ld}}   & ld_g)
                 | ({4{s_dec}}  & dec_g)
                 | ({4{s_wrap}} & wrap_g)
                 | ({4{s_hold}} & out);

    assign rl_d = ({4{s_ld}} & din) | ({4{clr & ~ld}} & rl_q);

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_bit
            ms_dff u_cnt (.clk(clk), .ce(1'b1), .d(out_d[i]), .q(out[i]));
            ms_dff u_rl  (.clk(clk), .ce(1'b1), .d(rl_d[i]),  .q(rl_q[i]));
        end
    endgenerate

    assign bin[3] = out[3];
    assign bin[2] = out[3] ^ out[2];
    assign bin[1] = out[3] ^ out[2] ^ out[1];
    assign bin[0] = out[3] ^ out[2] ^ out[1] ^ out[0];

    assign tc = zero & cten & ~ld & clr;
endmodule

// File: tb/tb_gray_down_counter_4b.sv
// Directed bench: wrap and auto-reload variants, a two-stage cascade, and priority corners.

module tb_gray_down_counter_4b;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // a_*: AUTO_RELOAD=0 stage, r_*: AUTO_RELOAD=1 stage, c_*: two chained stages
    logic       a_clr, a_cten, a_ld;
    logic [3:0] a_din, a_out, a_bin;
    logic       a_tc;
    logic       r_clr, r_cten, r_ld;
    logic [3:0] r_din, r_out, r_bin;
    logic       r_tc;
    logic       c_clr, c_cten, c_ld;
    logic [3:0] c_din, c0_out, c0_bin, c1_out, c1_bin;
    logic       c0_tc, c1_tc;

    gray_down_counter_4b #(.AUTO_RELOAD(1'b0)) u_a (
        .clk(clk), .clr(a_clr), .cten(a_cten), .ld(a_ld), .din(a_din),
        .out(a_out), .bin(a_bin), .tc(a_tc));
    gray_down_counter_4b #(.AUTO_RELOAD(1'b1)) u_r (
        .clk(clk), .clr(r_clr), .cten(r_cten), .ld(r_ld), .din(r_din),
        .out(r_out), .bin(r_bin), .tc(r_tc));
    gray_down_counter_4b #(.AUTO_RELOAD(1'b0)) u_c0 (
        .clk(clk), .clr(c_clr), .cten(c_cten), .ld(c_ld), .din(c_din),
        .out(c0_out), .bin(c0_bin), .tc(c0_tc));
    gray_down_counter_4b #(.AUTO_RELOAD(1'b0)) u_c1 (
        .clk(clk), .clr(c_clr), .cten(c0_tc), .ld(c_ld), .din(c_din),
        .out(c1_out), .bin(c1_bin), .tc(c1_tc));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Gray codes for binary 8 down to 0
    logic [3:0] dec_gray [9] = '{4'b1100, 4'b0100, 4'b0101, 4'b0111, 4'b0110,
                                 4'b0010, 4'b0011, 4'b0001, 4'b0000};
    logic [3:0] ar_seq   [6] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd5};
    logic [3:0] prev;

    initial begin
        a_clr = 0; a_cten = 0; a_ld = 0; a_din = 0;
        r_clr = 0; r_cten = 0; r_ld = 0; r_din = 0;
        c_clr = 0; c_cten = 0; c_ld = 0; c_din = 0;

        // 1: reset from unknown state, then hold
        tick();
        chk("rst_out", {4'h0, a_out}, 8'h00);
        chk("rst_bin", {4'h0, a_bin}, 8'h00);
        chk("rst_out_r", {4'h0, r_out}, 8'h00);
        a_clr = 1; r_clr = 1; c_clr = 1;
        repeat (3) tick();
        chk("hold_out", {4'h0, a_out}, 8'h00);
        chk("hold_tc", {7'h0, a_tc}, 8'h00);

        // 2: load 9, count down to 0
        a_ld = 1; a_din = 4'd9;
        tick();
        chk("ld9_out", {4'h0, a_out}, 8'b1101);
        chk("ld9_bin", {4'h0, a_bin}, 8'd9);
        a_ld = 0; a_cten = 1;
        for (int k = 0; k < 9; k++) begin
            #1;
            chk("dn_tc_pre", {7'h0, a_tc}, 8'h00);
            prev = a_out;
            tick();
            chk("dn_out", {4'h0, a_out}, {4'h0, dec_gray[k]});
            chk("dn_bin", {4'h0, a_bin}, 8'(8 - k));
            chk("dn_1bit", 8'($countones(prev ^ a_out)), 8'd1);
        end

        // 3: underflow wraps to 15, full loop back to 0
        #1;
        chk("uf_tc", {7'h0, a_tc}, 8'h01);
        tick();
        chk("uf_out", {4'h0, a_out}, 8'b1000);
        chk("uf_bin", {4'h0, a_bin}, 8'd15);
        chk("uf_tc_post", {7'h0, a_tc}, 8'h00);
        for (int k = 0; k < 15; k++) begin
            tick();
            chk("loop_bin", {4'h0, a_bin}, 8'(14 - k));
        end
        chk("loop_out", {4'h0, a_out}, 8'h00);

        // 4: auto-reload with preset 5
        r_ld = 1; r_din = 4'd5;
        tick();
        r_ld = 0; r_cten = 1;
        #1;
        chk("ar_tc0", {7'h0, r_tc}, 8'h00);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("ar_bin", {4'h0, r_bin}, {4'h0, ar_seq[k]});
            chk("ar_tc", {7'h0, r_tc}, (ar_seq[k] == 4'd0) ? 8'h01 : 8'h00);
        end
        // reload value 0 sticks at zero with tc every cycle
        r_ld = 1; r_din = 4'd0; r_cten = 0;
        tick();
        r_ld = 0; r_cten = 1;
        repeat (2) begin
            #1;
            chk("ar0_tc", {7'h0, r_tc}, 8'h01);
            tick();
            chk("ar0_out", {4'h0, r_out}, 8'h00);
        end
        r_cten = 0;

        // 5: two chained stages form an 8-bit down counter
        c_ld = 1; c_din = 4'd0;
        tick();
        c_ld = 0; c_cten = 1;
        #1;
        chk("ch_tc1", {7'h0, c1_tc}, 8'h01);
        tick();
        chk("ch_ff", {c1_bin, c0_bin}, 8'hFF);
        chk("ch_gray", {c1_out, c0_out}, 8'h88);
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("ch_cnt", {c1_bin, c0_bin}, 8'(8'hFF - k));
        end
        c_cten = 0;

        // 6: priority corners on the AUTO_RELOAD=0 stage (out is 0000 here)
        a_clr = 0; a_ld = 0; a_cten = 1;
        #1;
        chk("clr_tc", {7'h0, a_tc}, 8'h00);
        a_ld = 1; a_din = 4'd7;
        tick();
        chk("clr_win", {4'h0, a_out}, 8'h00);
        a_clr = 1; a_ld = 1; a_cten = 1; a_din = 4'd3;
        #1;
        chk("ld_tc", {7'h0, a_tc}, 8'h00);
        tick();
        chk("ld_win", {4'h0, a_out}, 8'b0010);
        a_ld = 0; a_cten = 0;
        tick();
        chk("ld_hold", {4'h0, a_bin}, 8'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gray_down_counter_4b.md
Name: gray_down_counter_4b

Overview:
Cascadable 4-bit Gray-code down counter. It is the count-down counterpart to the existing up-counting Gray stage in the timer datapath. It is loaded with a binary preset, decrements one Gray step per enabled clock, and issues a borrow/terminal-count pulse on underflow so that the next, more-significant stage can decrement. It also provides a decoded binary view of the count for compare and readback logic.

Parameters:
AUTO_RELOAD, 0, 0: on underflow, wrap 0000 -> gray(15) = 1000. 1: on underflow, reload the last value captured by ld.
RESET_VAL, 4'b0000, Gray value forced onto out by synchronous reset.

Ports:
clk  input  1  single clock; all state updates on its rising edge
clr  input  1  reset; synchronous, active-low
cten  input  1  count enable; decrement one Gray step when high
ld  input  1  synchronous parallel load strobe
din  input  4  binary preset value for ld
out  output  4  current count, Gray code
bin  output  4  current count decoded to binary (combinational from out)
tc  output  1  borrow / terminal count to next stage (combinational)

Behaviour:
- Reset: one clock; reset is synchronous and active-low.
  - clr sampled low at a rising clk edge: out <= RESET_VAL, reload register <= 4'b0000.
  - clr has no effect between edges.
  - With the default RESET_VAL: out = 0000, bin = 0000, tc = cten & ~ld.
- Priority at each edge: clr low > ld > cten > hold.
- Load (ld = 1, clr = 1):
  - out <= binary-to-Gray(din), i.e. g[3] = b[3], g[i] = b[i+1] ^ b[i].
  - Reload register <= din.
  - cten is ignored in a load cycle; no decrement occurs.
- Count (ld = 0, cten = 1): out advances one step down the Gray sequence:
  1000 (15) -> 1001 -> 1011 -> 1010 -> 1110 -> 1111 -> 1101 -> 1100 -> 0100 -> 0101 -> 0111 -> 0110 -> 0010 -> 0011 -> 0001 -> 0000 (0).
  - Exactly one bit of out changes per decrement.
- Underflow (out = 0000, cten = 1, ld = 0):
  - AUTO_RELOAD = 0: next out = 1000.
  - AUTO_RELOAD = 1: next out = Gray(reload register). A reload value of 0 keeps out at 0000 and tc pulses every enabled cycle.
- Hold (cten = 0, ld = 0): out unchanged.
- tc = (out == 0000) & cten & ~ld & clr.
  - Purely combinational, so a chained stage sees it in the same cycle. Wire it to the next stage's cten.
  - tc = 0 whenever clr is low.
- bin = Gray-to-binary(out): b[3] = g[3], b[i] = b[i+1] ^ g[i]. Zero latency.
- Implementation: next-state logic is explicit SOP gate logic driving four ms_dff instances, matching the team's gate-level style. The reload register and the mux are registered with ce = 1.
- Reset mid-count: an asserted clr wins over a simultaneous ld or cten; the count is lost.
- ld while out = 0000 and cten = 1: the load wins, tc = 0, and no borrow propagates.

Test Plan:
1. clr = 0 for 1 edge from unknown state -> out = 0000, bin = 0000. Then clr = 1, cten = 0, 3 edges -> out stays 0000, tc = 0.
2. ld = 1, din = 4'd9 -> after 1 edge out = 1101, bin = 9. Then cten = 1 for 9 edges -> bin steps 8, 7, ..., 0. Exactly one out bit toggles per edge. tc = 1 only while out = 0000.
3. AUTO_RELOAD = 0, out = 0000, cten = 1, 1 edge -> tc = 1 before the edge, out = 1000 and bin = 15 after. Full 16-edge loop returns to 0000.
4. AUTO_RELOAD = 1, ld with din = 5, then cten = 1 for 6 edges -> sequence 4, 3, 2, 1, 0, 5. tc is high exactly in the cycle where bin = 0.
5. Two stages chained (stage0.tc -> stage1.cten), both loaded with 0 and cten0 = 1 -> first edge: both out = 1000 (combined 0xFF). Stage1 decrements only on edges where stage0 bin = 0.
6. Simultaneous events: clr = 0 with ld = 1 and cten = 1 -> out = 0000. ld = 1 with cten = 1 at out = 0000, din = 3 -> out = 0010, tc = 0.
